iir_df1_biquad_axis: RTL and testbench

IIR_DF1_BIQUAD_AXIS -- requirements
Module: iir_df1_biquad_axis

---
 rtl/iir_df1_biquad_axis_pkg.sv | 34 +++
 rtl/iir_biquad_sat.sv | 20 ++
 rtl/iir_df1_biquad_axis.sv | 118 +++++++++++
 tb/tb_iir_df1_biquad_axis.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/iir_df1_biquad_axis_pkg.sv
// Shared constants, FSM encoding and saturation helper for the DF-I biquad filter.
package iir_df1_biquad_axis_pkg;

    // Headroom above a full-precision product so the five-term sum cannot overflow.
    localparam int unsigned acc_guard_bits = 3;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StSum,
        StOut
    } state_e;

    function automatic int unsigned acc_bits(input int unsigned coeff_w,
                                             input int unsigned sample_w);
        return coeff_w + sample_w + acc_guard_bits;
    endfunction

    // Clamp v into the signed range of a width-bit word; the caller truncates to width bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/iir_biquad_sat.sv
// Scales the biquad accumulator back to sample precision (floor shift) and saturates it.
module iir_biquad_sat
    import iir_df1_biquad_axis_pkg::*;
#(
    parameter int unsigned acc_width    = 35,
    parameter int unsigned inout_width  = 16,
    parameter int unsigned scale_factor = 14
) (
    input  logic signed [acc_width-1:0]   acc,
    output logic signed [inout_width-1:0] y
);

    logic signed [acc_width-1:0] shifted;

    always_comb begin
        shifted = acc >>> scale_factor;
        y       = inout_width'(saturate(64'(shifted), inout_width));
    end

endmodule

// File: rtl/iir_df1_biquad_axis.sv
// Direct Form I biquad with fixed coefficients; one sample per four cycles, three-cycle latency.
module iir_df1_biquad_axis
    import iir_df1_biquad_axis_pkg::*;
#(
    parameter int unsigned coeff_width  = 16,
    parameter int unsigned inout_width  = 16,
    parameter int unsigned scale_factor = 14,
    parameter int          a1_int_coeff = -31880,
    parameter int          a2_int_coeff = 15531,
    parameter int          bo_int_coeff = 167,
    parameter int          b1_int_coeff = -302,
    parameter int          b2_int_coeff = 167
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_axis_tvalid,
    input  logic signed [inout_width-1:0] s_axis_tdata,
    output logic                          m_axis_tready,
    output logic signed [inout_width-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid
);

    localparam int unsigned prod_width = coeff_width + inout_width;
    localparam int unsigned acc_width  = acc_bits(coeff_width, inout_width);

    localparam logic signed [coeff_width-1:0] b0_c = coeff_width'(bo_int_coeff);
    localparam logic signed [coeff_width-1:0] b1_c = coeff_width'(b1_int_coeff);
    localparam logic signed [coeff_width-1:0] b2_c = coeff_width'(b2_int_coeff);
    localparam logic signed [coeff_width-1:0] a1_c = coeff_width'(a1_int_coeff);
    localparam logic signed [coeff_width-1:0] a2_c = coeff_width'(a2_int_coeff);

    state_e state_q;
    state_e state_d;
    logic   accept;
    logic   valid_q;

    // x0_q is the sample in flight; y1_q doubles as the output register.
    logic signed [inout_width-1:0] x0_q, x1_q, x2_q, y1_q, y2_q;
    logic signed [inout_width-1:0] y_sat;
    logic signed [prod_width-1:0]  prod_d [5];
    logic signed [prod_width-1:0]  prod_q [5];
    logic signed [acc_width-1:0]   sum_d;
    logic signed [acc_width-1:0]   sum_q;

    always_comb begin
        state_d       = state_q;
        m_axis_tready = 1'b0;
        accept        = 1'b0;
        unique case (state_q)
            StIdle: begin
                m_axis_tready = 1'b1;
                accept        = s_axis_tvalid;
                if (s_axis_tvalid) begin
                    state_d = StMul;
                end
            end
            StMul:   state_d = StSum;
            StSum:   state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        prod_d[0] = prod_width'(b0_c) * prod_width'(x0_q);
        prod_d[1] = prod_width'(b1_c) * prod_width'(x1_q);
        prod_d[2] = prod_width'(b2_c) * prod_width'(x2_q);
        prod_d[3] = prod_width'(a1_c) * prod_width'(y1_q);
        prod_d[4] = prod_width'(a2_c) * prod_width'(y2_q);
        sum_d     = acc_width'(prod_q[0]) + acc_width'(prod_q[1]) + acc_width'(prod_q[2])
                  - acc_width'(prod_q[3]) - acc_width'(prod_q[4]);
    end

    iir_biquad_sat #(
        .acc_width    (acc_width),
        .inout_width  (inout_width),
        .scale_factor (scale_factor)
    ) u_sat (
        .acc (sum_q),
        .y   (y_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            x0_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            prod_q  <= '{default: '0};
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_q == StOut);
            if (accept) begin
                x0_q <= s_axis_tdata;
            end
            if (state_q == StMul) begin
                prod_q <= prod_d;
            end
            if (state_q == StSum) begin
                sum_q <= sum_d;
            end
            if (state_q == StOut) begin
                x2_q <= x1_q;
                x1_q <= x0_q;
                y2_q <= y1_q;
                y1_q <= y_sat;
            end
        end
    end

    assign m_axis_tdata  = y1_q;
    assign m_axis_tvalid = valid_q;

endmodule

// File: tb/tb_iir_df1_biquad_axis.sv
// Directed bench for the DF-I biquad: reset, impulse, busy drop, mid-flight reset,
// saturation and a long step run against an integer recurrence.
module tb_iir_df1_biquad_axis;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic signed [15:0] s_data;
    logic               ready;
    logic signed [15:0] m_data;
    logic               m_valid;
    logic               sat_valid;
    logic signed [15:0] sat_in;
    logic               sat_ready;
    logic signed [15:0] sat_data;
    logic               sat_mvalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iir_df1_biquad_axis dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .m_axis_tready (ready),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid)
    );

    iir_df1_biquad_axis #(
        .a1_int_coeff (0),
        .a2_int_coeff (0),
        .bo_int_coeff (32767),
        .b1_int_coeff (0),
        .b2_int_coeff (0)
    ) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (sat_valid),
        .s_axis_tdata  (sat_in),
        .m_axis_tready (sat_ready),
        .m_axis_tdata  (sat_data),
        .m_axis_tvalid (sat_mvalid)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        s_valid   = 1'b0;
        sat_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // One sample in, result expected exactly three edges after acceptance as a one-cycle pulse.
    task automatic send(input string tag, input longint x, input longint exp);
        logic [63:0] xv;
        xv = x;
        check({tag, "_ready"}, ready, 1);
        s_data  = xv[15:0];
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        check({tag, "_early_valid"}, m_valid, 0);
        tick();
        check({tag, "_valid"}, m_valid, 1);
        check({tag, "_data"}, m_data, exp);
        tick();
        check({tag, "_pulse_end"}, m_valid, 0);
    endtask

    task automatic sat_send(input string tag, input longint x, input longint exp);
        logic [63:0] xv;
        xv = x;
        sat_in    = xv[15:0];
        sat_valid = 1'b1;
        tick();
        sat_valid = 1'b0;
        repeat (3) tick();
        check({tag, "_valid"}, sat_mvalid, 1);
        check({tag, "_data"}, sat_data, exp);
        tick();
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    initial begin
        int     pulses;
        longint mx1, mx2, my1, my2, acc, y;

        s_data = '0;
        sat_in = '0;

        do_reset(5);
        check("reset_data", m_data, 0);
        check("reset_valid", m_valid, 0);
        check("reset_ready", ready, 1);
        check("reset_sat_ready", sat_ready, 1);

        // A sample presented while reset is asserted must not be taken.
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'sd16384;
        tick();
        rst     = 1'b0;
        s_valid = 1'b0;
        check("no_accept_in_reset", ready, 1);

        send("imp0", 16384, 167);
        send("imp1", 0, 22);
        send("imp2", 0, 51);
        send("imp3", 0, 78);

        // Busy drop: valid while busy is ignored and history stays intact.
        do_reset(2);
        s_data  = 16'sd16384;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("busy_ready_mul", ready, 0);
        s_data  = 16'sd20000;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("busy_ready_sum", ready, 0);
        s_data  = -16'sd20000;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("busy_ready_out", ready, 0);
        tick();
        check("busy_valid", m_valid, 1);
        check("busy_data", m_data, 167);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_valid) pulses++;
        end
        check("busy_extra_pulses", pulses, 0);
        send("busy_next", 0, 22);

        // Reset one cycle after acceptance aborts the sample.
        do_reset(2);
        s_data  = 16'sd16384;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_data", m_data, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_valid) pulses++;
            tick();
        end
        check("abort_pulses", pulses, 0);
        send("abort_imp0", 16384, 167);
        send("abort_imp1", 0, 22);

        sat_send("sat_pos", 32767, 32767);
        sat_send("sat_neg", -32768, -32768);
        sat_send("sat_edge_pos", 16384, 32767);
        sat_send("sat_edge_neg", -16384, -32767);

        // Step response against the DF-I recurrence in integer arithmetic.
        do_reset(2);
        mx1 = 0;
        mx2 = 0;
        my1 = 0;
        my2 = 0;
        for (int n = 0; n < 2000; n++) begin
            acc = 167 * 10000 + (-302) * mx1 + 167 * mx2 - (-31880) * my1 - 15531 * my2;
            y   = sat16(acc >>> 14);
            send($sformatf("step%0d", n), 10000, y);
            mx2 = mx1;
            mx1 = 10000;
            my2 = my1;
            my1 = y;
        end
        $display("step response settled at %0d", m_data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
